// File: rtl/collision_scan_sequencer.sv
// collision_scan_sequencer: once per frame, walks the four edges of the sprite
// bounding box (TOP, BOTTOM, LEFT, RIGHT). It issues background reads under a
// req/grant handshake and returns each pixel tagged with its edge and
// end-of-edge flag.
// Optional: define SCAN_ABORT_EN to add the abort input / aborted output.
module collision_scan_sequencer #(
   parameter int SPRITE_SIZE = 16,
   parameter int RD_LATENCY  = 2,
   parameter int COORD_W     = 10
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [COORD_W-1:0] sp_x,
   input  logic [COORD_W-1:0] sp_y,
   output logic               rd_req,
   input  logic               rd_grant,
   output logic [COORD_W-1:0] rd_x,
   output logic [COORD_W-1:0] rd_y,
   input  logic [23:0]        bg_rgb,
   output logic               acc_clear,
   output logic               sample_valid,
   output logic [23:0]        sample_rgb,
   output logic [1:0]         sample_edge,
   output logic               sample_last,
   output logic               busy,
   output logic               done
`ifdef SCAN_ABORT_EN
   ,
   input  logic               abort,
   output logic               aborted
`endif
);

   localparam int IDXW = (SPRITE_SIZE > 1) ? $clog2(SPRITE_SIZE) : 1;
   localparam int CNTW = $clog2(RD_LATENCY + 2);

   typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_SCAN, S_DRAIN, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [COORD_W-1:0]  spx_q, spy_q;
   logic [1:0]          edge_q, edge_d;
   logic [IDXW-1:0]     idx_q, idx_d;
   logic [COORD_W-1:0]  rd_x_q, rd_y_q, rdx_d, rdy_d;
   logic [RD_LATENCY-1:0]      tag_vld_q;
   logic [RD_LATENCY-1:0][1:0] tag_edge_q;
   logic [RD_LATENCY-1:0]      tag_last_q;
   logic [CNTW-1:0]     inflight_q;
   logic                sample_valid_q, sample_last_q;
   logic [23:0]         sample_rgb_q;
   logic [1:0]          sample_edge_q;
   logic                accept, last_idx, emerge, abort_hit;

   assign accept   = rd_req & rd_grant;
   assign last_idx = (idx_q == IDXW'(SPRITE_SIZE - 1));
   assign emerge   = tag_vld_q[RD_LATENCY-1];

`ifdef SCAN_ABORT_EN
   logic aborted_q;
   assign abort_hit = abort & ((state_q == S_CLEAR) | (state_q == S_SCAN) | (state_q == S_DRAIN));
   assign aborted   = aborted_q;

   // One-cycle acknowledge of an accepted abort.
   always_ff @(posedge clk) begin
      if (rst) aborted_q <= 1'b0;
      else     aborted_q <= abort_hit;
   end
`else
   assign abort_hit = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic; drain waits until every accepted read has come back.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (start) state_d = S_CLEAR;
         S_CLEAR: state_d = S_SCAN;
         S_SCAN:  if (accept && edge_q == 2'd3 && last_idx) state_d = S_DRAIN;
         S_DRAIN: if (inflight_q == '0) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (abort_hit) state_d = S_IDLE;
   end

   // Moore outputs decoded from state.
   always_comb begin
      rd_req    = (state_q == S_SCAN);
      acc_clear = (state_q == S_CLEAR);
      busy      = (state_q != S_IDLE);
      done      = (state_q == S_DONE);
   end

   // Walk position: idx advances only on acceptance, edge steps at end of side.
   always_comb begin
      edge_d = edge_q;
      idx_d  = idx_q;
      if (state_q == S_CLEAR) begin
         edge_d = 2'd0;
         idx_d  = '0;
      end else if (state_q == S_SCAN && accept) begin
         if (last_idx) begin
            idx_d  = '0;
            edge_d = edge_q + 2'd1;
         end else begin
            idx_d  = idx_q + IDXW'(1);
         end
      end
   end

   // Coordinate of the next request; corners are visited twice on purpose.
   always_comb begin
      rdx_d = spx_q;
      rdy_d = spy_q;
      unique case (edge_d)
         2'd0: begin rdx_d = spx_q + COORD_W'(idx_d);           rdy_d = spy_q; end
         2'd1: begin rdx_d = spx_q + COORD_W'(idx_d);           rdy_d = spy_q + COORD_W'(SPRITE_SIZE - 1); end
         2'd2: begin rdx_d = spx_q;                             rdy_d = spy_q + COORD_W'(idx_d); end
         default: begin rdx_d = spx_q + COORD_W'(SPRITE_SIZE - 1); rdy_d = spy_q + COORD_W'(idx_d); end
      endcase
   end

   // Datapath: anchor latch, walk regs, request coords, tag pipe, sample regs.
   always_ff @(posedge clk) begin
      if (rst) begin
         spx_q          <= '0;
         spy_q          <= '0;
         edge_q         <= 2'd0;
         idx_q          <= '0;
         rd_x_q         <= '0;
         rd_y_q         <= '0;
         tag_vld_q      <= '0;
         tag_edge_q     <= '0;
         tag_last_q     <= '0;
         inflight_q     <= '0;
         sample_valid_q <= 1'b0;
         sample_last_q  <= 1'b0;
         sample_rgb_q   <= '0;
         sample_edge_q  <= 2'd0;
      end else begin
         if (state_q == S_IDLE && start) begin
            spx_q <= sp_x;
            spy_q <= sp_y;
         end
         edge_q <= edge_d;
         idx_q  <= idx_d;
         // Coordinates only move while scanning, so they hold through stalls.
         if (state_d == S_SCAN) begin
            rd_x_q <= rdx_d;
            rd_y_q <= rdy_d;
         end
         for (int i = RD_LATENCY - 1; i > 0; i--) begin
            tag_vld_q[i]  <= tag_vld_q[i-1];
            tag_edge_q[i] <= tag_edge_q[i-1];
            tag_last_q[i] <= tag_last_q[i-1];
         end
         tag_vld_q[0]  <= accept;
         tag_edge_q[0] <= edge_q;
         tag_last_q[0] <= last_idx;
         inflight_q    <= inflight_q + CNTW'(accept) - CNTW'(emerge);
         if (abort_hit) begin
            tag_vld_q  <= '0;
            inflight_q <= '0;
         end
         sample_valid_q <= emerge & ~abort_hit;
         sample_last_q  <= emerge & tag_last_q[RD_LATENCY-1] & ~abort_hit;
         if (emerge) begin
            sample_rgb_q  <= bg_rgb;
            sample_edge_q <= tag_edge_q[RD_LATENCY-1];
         end
      end
   end

   assign rd_x         = rd_x_q;
   assign rd_y         = rd_y_q;
   assign sample_valid = sample_valid_q;
   assign sample_rgb   = sample_rgb_q;
   assign sample_edge  = sample_edge_q;
   assign sample_last  = sample_last_q;

endmodule
